// File: rtl/spi_boot_loader.sv
// -----------------------------------------------------------------------------
// spi_boot_loader
//
// Receives a program image over an SPI mode-0 slave link and replays it as
// single-word AHB-Lite write transfers on the memory router's SPI master port.
// While loading, SPI_change is held low so the router services only this port.
// Once the last word has been written, SPI_change rises and ownership of the
// memories passes to the RISC-V core buses.
//
// Frame on the wire (MSB first, 32-bit words):
//   word 0     : header, [31:16] = word count N, [15:0] = start byte address
//   words 1..N : data, written to consecutive word addresses
//
// Ports
//   clk            system clock, all logic on its rising edge
//   reset          synchronous, active-low reset
//   sclk           SPI clock from the host (asynchronous to clk)
//   cs_n           SPI chip select, active-low (asynchronous)
//   mosi           SPI serial data in, MSB first (asynchronous)
//   spi_haddr      AHB address, {16'h0000, word address, 2'b00}
//   spi_hwdata     AHB write data
//   spi_hwrite     1 during an address phase
//   spi_hsize      constant word size
//   spi_hburst     constant SINGLE burst
//   spi_hprot      constant protection attributes
//   spi_hmastlock  constant 0
//   spi_htrans     NONSEQ in the address phase, IDLE otherwise
//   spi_hready     transfer-phase completion from the router
//   spi_hresp      1 = ERROR response
//   SPI_change     0 = loader owns the router, 1 = load complete
//   load_error     sticky error flag (bus error, overrun or aborted frame)
// -----------------------------------------------------------------------------
module spi_boot_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic [31:0] spi_haddr,
    output logic [31:0] spi_hwdata,
    output logic        spi_hwrite,
    output logic [2:0]  spi_hsize,
    output logic [2:0]  spi_hburst,
    output logic [3:0]  spi_hprot,
    output logic        spi_hmastlock,
    output logic [1:0]  spi_htrans,
    input  logic        spi_hready,
    input  logic        spi_hresp,
    output logic        SPI_change,
    output logic        load_error
);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HDR,
        RX_DATA,
        RX_DONE
    } rx_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_ADDR,
        A_DATA
    } ahb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Fixed transfer attributes: single 32-bit non-locked data accesses.
    assign spi_hsize     = 3'b010;
    assign spi_hburst    = 3'b000;
    assign spi_hprot     = 4'b0011;
    assign spi_hmastlock = 1'b0;

    // -------------------------------------------------------------------------
    // Input synchronisers. mosi goes through the same depth as sclk so the
    // data bit is aligned with the clock edge that qualifies it.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // flops sample the pre-edge values and the synchroniser chain shifts
        // by exactly one stage per clock.
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;   // come out of reset deselected
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Loader state
    // -------------------------------------------------------------------------
    rx_state_t   rx_state;
    ahb_state_t  ahb_state;
    logic [30:0] shift_reg;    // only 31 bits kept: the 32nd arrives with mosi_s
    logic [4:0]  bit_cnt;
    logic [13:0] addr_w;       // word address; byte bits [1:0] are never used
    logic [15:0] remaining;    // words still to be written
    logic [31:0] hold_word;    // one-word buffer between SPI and AHB sides
    logic        pend;         // hold_word holds a word not yet written

    logic        sclk_rise;
    logic        shift_en;
    logic        word_done;
    logic [31:0] word_in;
    logic        wr_done;
    logic        abort_data;

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign shift_en  = sclk_rise & ~cs_s &
                       ((rx_state == RX_HDR) || (rx_state == RX_DATA));
    // The counter wraps from 31 to 0 on the bit that completes a word.
    assign word_done = shift_en & (bit_cnt == 5'd31);
    assign word_in   = {shift_reg, mosi_s};
    assign wr_done   = (ahb_state == A_DATA) & spi_hready;

    // Chip select may legitimately rise once every word has been received
    // while the final write is still in flight (remaining == pend == 1);
    // any earlier release is an aborted frame.
    assign abort_data = cs_s & (remaining != {15'd0, pend});

    // -------------------------------------------------------------------------
    // Receive FSM and AHB write engine share addr_w/remaining/pend, so both
    // live in one clocked process. The receive section is written after the
    // AHB section: when a write completes in the same cycle a new word
    // arrives, the AHB side clears pend and the receive side then sets it
    // again, so the new word is captured instead of counted as an overrun.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            ahb_state  <= A_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            addr_w     <= '0;
            remaining  <= '0;
            hold_word  <= '0;
            pend       <= 1'b0;
            spi_haddr  <= '0;
            spi_hwdata <= '0;
            spi_hwrite <= 1'b0;
            spi_htrans <= HTRANS_IDLE;
            SPI_change <= 1'b0;
            load_error <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg <= word_in[30:0];
                bit_cnt   <= bit_cnt + 5'd1;
            end

            // ---------------- AHB write engine ----------------
            case (ahb_state)
                A_IDLE: begin
                    // haddr and hwdata are loaded together and then held
                    // untouched until the data phase completes.
                    if (pend && (rx_state == RX_DATA)) begin
                        spi_htrans <= HTRANS_NONSEQ;
                        spi_hwrite <= 1'b1;
                        spi_haddr  <= {16'h0000, addr_w, 2'b00};
                        spi_hwdata <= hold_word;
                        ahb_state  <= A_ADDR;
                    end
                end
                A_ADDR: begin
                    if (spi_hready) begin
                        spi_htrans <= HTRANS_IDLE;
                        spi_hwrite <= 1'b0;
                        ahb_state  <= A_DATA;
                    end
                end
                A_DATA: begin
                    if (spi_hready) begin
                        // An ERROR response still retires the word.
                        if (spi_hresp) begin
                            load_error <= 1'b1;
                        end
                        pend      <= 1'b0;
                        ahb_state <= A_IDLE;
                        // After an abort the counters are already cleared;
                        // a write that was in flight just drains.
                        if (rx_state == RX_DATA) begin
                            addr_w    <= addr_w + 14'd1;
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                rx_state   <= RX_DONE;
                                SPI_change <= 1'b1;
                            end
                        end
                    end
                end
                default: ahb_state <= A_IDLE;
            endcase

            // ---------------- Receive FSM ----------------
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    if (!cs_s) begin
                        rx_state <= RX_HDR;
                    end
                end
                RX_HDR: begin
                    if (cs_s) begin
                        rx_state   <= RX_IDLE;
                        bit_cnt    <= '0;
                        shift_reg  <= '0;
                        addr_w     <= '0;
                        remaining  <= '0;
                        load_error <= 1'b1;
                    end else if (word_done) begin
                        addr_w    <= word_in[15:2];
                        remaining <= word_in[31:16];
                        if (word_in[31:16] == 16'd0) begin
                            rx_state   <= RX_DONE;
                            SPI_change <= 1'b1;
                        end else begin
                            rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (abort_data) begin
                        rx_state   <= RX_IDLE;
                        bit_cnt    <= '0;
                        shift_reg  <= '0;
                        addr_w     <= '0;
                        remaining  <= '0;
                        pend       <= 1'b0;
                        load_error <= 1'b1;
                    end else if (word_done) begin
                        if (pend && !wr_done) begin
                            // Overrun: the buffer is still busy, drop the word.
                            load_error <= 1'b1;
                        end else begin
                            hold_word <= word_in;
                            pend      <= 1'b1;
                        end
                    end
                end
                RX_DONE: begin
                    // Terminal until reset; the SPI link is ignored.
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_boot_loader
//
// Drives SPI frames from a host model and acts as the AHB router: a responder
// process inserts per-transfer wait states / ERROR responses from queues and
// records every completed write. Each test task compares the recorded writes
// and status flags against expectations computed from the frame contents.
// -----------------------------------------------------------------------------
module tb_spi_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        spi_hready = 1'b1;
    logic        spi_hresp = 1'b0;
    logic [31:0] spi_haddr;
    logic [31:0] spi_hwdata;
    logic        spi_hwrite;
    logic [2:0]  spi_hsize;
    logic [2:0]  spi_hburst;
    logic [3:0]  spi_hprot;
    logic        spi_hmastlock;
    logic [1:0]  spi_htrans;
    logic        SPI_change;
    logic        load_error;

    spi_boot_loader #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .spi_haddr     (spi_haddr),
        .spi_hwdata    (spi_hwdata),
        .spi_hwrite    (spi_hwrite),
        .spi_hsize     (spi_hsize),
        .spi_hburst    (spi_hburst),
        .spi_hprot     (spi_hprot),
        .spi_hmastlock (spi_hmastlock),
        .spi_htrans    (spi_htrans),
        .spi_hready    (spi_hready),
        .spi_hresp     (spi_hresp),
        .SPI_change    (SPI_change),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
        int          dcyc;   // data-phase cycles including the completing one
    } xfer_t;

    xfer_t       obs_q[$];
    int          stall_q[$];
    bit          err_q[$];
    logic [31:0] tx_q[$];

    int    neg_cnt = 0;
    int    last_cmpl = -1;
    int    rise_cyc = -1;
    bit    dphase = 1'b0;
    bit    prev_sc = 1'b0;
    int    stall_left = 0;
    xfer_t cur;

    // Expected byte address of the i-th write of a frame starting at 'start'.
    function automatic logic [31:0] exp_addr(input logic [15:0] start, input int i);
        int a;
        a = ((int'(start) / 4) * 4 + 4 * i) % 65536;
        return 32'(a);
    endfunction

    // ---------------- AHB router model / monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (!reset) begin
                dphase     = 1'b0;
                prev_sc    = 1'b0;
                spi_hready = 1'b1;
                spi_hresp  = 1'b0;
            end else begin
                if (SPI_change === 1'b1 && !prev_sc) rise_cyc = neg_cnt;
                prev_sc = (SPI_change === 1'b1);
                if (dphase) begin
                    cur.dcyc++;
                    checks++;
                    if (spi_haddr !== cur.addr || spi_hwdata !== cur.data || spi_htrans !== 2'b00) begin
                        errors++;
                        $display("FAIL data_phase_hold: haddr=%h hwdata=%h htrans=%b, required haddr=%h hwdata=%h htrans=00",
                                 spi_haddr, spi_hwdata, spi_htrans, cur.addr, cur.data);
                    end
                    if (stall_left > 0) begin
                        spi_hready = 1'b0;
                        spi_hresp  = 1'b0;
                        stall_left--;
                    end else begin
                        spi_hready = 1'b1;
                        spi_hresp  = cur.err;
                        obs_q.push_back(cur);
                        last_cmpl = neg_cnt;
                        dphase = 1'b0;
                        checks++;
                        if (SPI_change !== 1'b0) begin
                            errors++;
                            $display("FAIL change_during_write: SPI_change=%b, required 0", SPI_change);
                        end
                    end
                end else begin
                    spi_hready = 1'b1;
                    spi_hresp  = 1'b0;
                    if (spi_htrans === 2'b10) begin
                        checks++;
                        if (spi_hwrite !== 1'b1 || spi_haddr[31:16] !== 16'h0 || spi_haddr[1:0] !== 2'b00) begin
                            errors++;
                            $display("FAIL addr_phase: hwrite=%b haddr=%h, required hwrite=1 haddr=0000xxxx aligned",
                                     spi_hwrite, spi_haddr);
                        end
                        cur.addr = spi_haddr;
                        cur.data = spi_hwdata;
                        cur.dcyc = 0;
                        cur.err  = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
                        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                        dphase = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- host / housekeeping tasks ----------------
    task automatic do_reset();
        reset = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        obs_q.delete();
        stall_q.delete();
        err_q.delete();
        tx_q.delete();
        rise_cyc  = -1;
        last_cmpl = -1;
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Host edges land 3 time units before a rising clk edge, never on it.
    task automatic spi_begin();
        @(negedge clk);
        #2;
        cs_n = 1'b0;
        #200;
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[31-i];
            #40;
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        #200;
        cs_n = 1'b1;
        #200;
    endtask

    task automatic spi_frame(input logic [31:0] hdr, input int nfull, input int partial);
        spi_begin();
        spi_bits(hdr, 32);
        for (int i = 0; i < nfull; i++) spi_bits(tx_q[i], 32);
        if (partial > 0) spi_bits(tx_q[nfull], partial);
        spi_end();
    endtask

    task automatic wait_change(input int bound);
        int k;
        k = 0;
        while (SPI_change !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (SPI_change !== 1'b1) begin
            errors++;
            $display("FAIL change_timeout: SPI_change=%b after %0d cycles, required 1", SPI_change, bound);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (spi_haddr !== 32'h0 || spi_hwdata !== 32'h0 || spi_htrans !== 2'b00 || spi_hwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: haddr=%h hwdata=%h htrans=%b hwrite=%b, required all zero",
                     spi_haddr, spi_hwdata, spi_htrans, spi_hwrite);
        end
        checks++;
        if (SPI_change !== 1'b0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: SPI_change=%b load_error=%b, required 0 0", SPI_change, load_error);
        end
        checks++;
        if (spi_hsize !== 3'b010 || spi_hburst !== 3'b000 || spi_hprot !== 4'b0011 || spi_hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: hsize=%b hburst=%b hprot=%b hmastlock=%b, required 010 000 0011 0",
                     spi_hsize, spi_hburst, spi_hprot, spi_hmastlock);
        end
    endtask

    task automatic test_basic();
        do_reset();
        tx_q.push_back(32'hDEADBEEF);
        tx_q.push_back(32'h01234567);
        spi_frame(32'h0002_4000, 2, 0);
        wait_change(100);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL basic_count: %0d writes, required 2", obs_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                errors++;
                $display("FAIL basic_write%0d: no write, required addr=%h data=%h", i, exp_addr(16'h4000, i), tx_q[i]);
            end else if (obs_q[i].addr !== exp_addr(16'h4000, i) || obs_q[i].data !== tx_q[i]) begin
                errors++;
                $display("FAIL basic_write%0d: addr=%h data=%h, required addr=%h data=%h",
                         i, obs_q[i].addr, obs_q[i].data, exp_addr(16'h4000, i), tx_q[i]);
            end
        end
        checks++;
        if (rise_cyc != last_cmpl + 1) begin
            errors++;
            $display("FAIL basic_change_timing: rise at cycle %0d, required %0d", rise_cyc, last_cmpl + 1);
        end
        checks++;
        if (load_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_error: load_error=%b, required 0", load_error);
        end
        // After completion the SPI link is ignored.
        spi_begin();
        spi_bits(32'h1234_5678, 32);
        spi_end();
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 2 || SPI_change !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_spi: writes=%0d SPI_change=%b, required 2 1", obs_q.size(), SPI_change);
        end
    endtask

    task automatic test_zero_words();
        do_reset();
        spi_begin();
        checks++;
        if (SPI_change !== 1'b0) begin
            errors++;
            $display("FAIL zero_before_hdr: SPI_change=%b, required 0", SPI_change);
        end
        spi_bits(32'h0000_0000, 32);
        spi_end();
        wait_change(100);
        checks++;
        if (obs_q.size() != 0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL zero_words: writes=%0d load_error=%b, required 0 0", obs_q.size(), load_error);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tx_q.push_back(32'h0000_00FF);
        stall_q.push_back(3);
        spi_frame(32'h0001_8004, 1, 0);
        wait_change(100);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL stall_count: %0d writes, required 1", obs_q.size());
        end else if (obs_q[0].addr !== 32'h0000_8004 || obs_q[0].data !== 32'h0000_00FF || obs_q[0].dcyc != 4) begin
            errors++;
            $display("FAIL stall_write: addr=%h data=%h data_cycles=%0d, required 00008004 000000ff 4",
                     obs_q[0].addr, obs_q[0].data, obs_q[0].dcyc);
        end
        checks++;
        if (rise_cyc != last_cmpl + 1 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: rise=%0d load_error=%b, required rise=%0d load_error=0",
                     rise_cyc, load_error, last_cmpl + 1);
        end
    endtask

    task automatic test_abort();
        do_reset();
        tx_q.push_back(32'hA5A5_0001);
        tx_q.push_back(32'h5A5A_0002);
        spi_frame(32'h0003_0000, 1, 20);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL abort_count: %0d writes, required 1", obs_q.size());
        end else if (obs_q[0].addr !== 32'h0 || obs_q[0].data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL abort_write: addr=%h data=%h, required 00000000 a5a50001", obs_q[0].addr, obs_q[0].data);
        end
        checks++;
        if (load_error !== 1'b1 || SPI_change !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: load_error=%b SPI_change=%b, required 1 0", load_error, SPI_change);
        end
        // Back in IDLE: a fresh frame loads without reset, error stays sticky.
        tx_q.delete();
        tx_q.push_back(32'hC0FF_EE00);
        spi_frame(32'h0001_0100, 1, 0);
        wait_change(100);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL abort_reload_count: %0d writes, required 2", obs_q.size());
        end else if (obs_q[1].addr !== 32'h0000_0100 || obs_q[1].data !== 32'hC0FF_EE00) begin
            errors++;
            $display("FAIL abort_reload: addr=%h data=%h, required 00000100 c0ffee00", obs_q[1].addr, obs_q[1].data);
        end
        checks++;
        if (load_error !== 1'b1) begin
            errors++;
            $display("FAIL abort_sticky: load_error=%b, required 1", load_error);
        end
    endtask

    task automatic test_wrap_hresp();
        do_reset();
        tx_q.push_back($urandom);
        tx_q.push_back($urandom);
        err_q.push_back(1'b1);
        spi_frame(32'h0002_FFFC, 2, 0);
        wait_change(100);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: %0d writes, required 2", obs_q.size());
        end else if (obs_q[0].addr !== 32'h0000_FFFC || obs_q[1].addr !== 32'h0 ||
                     obs_q[0].data !== tx_q[0] || obs_q[1].data !== tx_q[1]) begin
            errors++;
            $display("FAIL wrap_writes: %h/%h %h/%h, required 0000fffc/%h 00000000/%h",
                     obs_q[0].addr, obs_q[0].data, obs_q[1].addr, obs_q[1].data, tx_q[0], tx_q[1]);
        end
        checks++;
        if (load_error !== 1'b1) begin
            errors++;
            $display("FAIL wrap_hresp_error: load_error=%b, required 1", load_error);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        tx_q.push_back(32'h1111_1111);
        tx_q.push_back(32'h2222_2222);
        stall_q.push_back(300);   // longer than one SPI word
        spi_frame(32'h0002_2000, 2, 0);
        repeat (400) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL overrun_count: %0d writes, required 1", obs_q.size());
        end else if (obs_q[0].addr !== 32'h0000_2000 || obs_q[0].data !== 32'h1111_1111) begin
            errors++;
            $display("FAIL overrun_write: addr=%h data=%h, required 00002000 11111111", obs_q[0].addr, obs_q[0].data);
        end
        checks++;
        if (load_error !== 1'b1 || SPI_change !== 1'b0) begin
            errors++;
            $display("FAIL overrun_flags: load_error=%b SPI_change=%b, required 1 0", load_error, SPI_change);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int          n;
            logic [15:0] start;
            bit          any_err;
            bit          b;
            do_reset();
            n = $urandom_range(1, 4);
            start = 16'($urandom);
            any_err = 1'b0;
            for (int i = 0; i < n; i++) begin
                tx_q.push_back($urandom);
                stall_q.push_back($urandom_range(0, 3));
                b = ($urandom_range(0, 3) == 0);
                err_q.push_back(b);
                any_err |= b;
            end
            spi_frame({16'(n), start}, n, 0);
            wait_change(200);
            checks++;
            if (obs_q.size() != n) begin
                errors++;
                $display("FAIL rand%0d_count: %0d writes, required %0d", it, obs_q.size(), n);
            end
            for (int i = 0; i < n && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i].addr !== exp_addr(start, i) || obs_q[i].data !== tx_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: addr=%h data=%h, required addr=%h data=%h",
                             it, i, obs_q[i].addr, obs_q[i].data, exp_addr(start, i), tx_q[i]);
                end
            end
            checks++;
            if (load_error !== any_err || rise_cyc != last_cmpl + 1) begin
                errors++;
                $display("FAIL rand%0d_done: load_error=%b rise=%0d, required load_error=%b rise=%0d",
                         it, load_error, rise_cyc, any_err, last_cmpl + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        int          k;
        do_reset();
        w = $urandom;
        spi_begin();
        spi_bits(32'h0001_1000, 32);
        spi_bits(w, 31);
        mosi = w[0];
        #40;
        sclk = 1'b1;
        k = 0;
        while (spi_htrans !== 2'b10 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (spi_htrans !== 2'b10) begin
            errors++;
            $display("FAIL midreset_nonseq: htrans=%b after %0d cycles, required 10", spi_htrans, k);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (spi_haddr !== 32'h0 || spi_hwdata !== 32'h0 || spi_htrans !== 2'b00 || spi_hwrite !== 1'b0 ||
            SPI_change !== 1'b0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: haddr=%h hwdata=%h htrans=%b hwrite=%b chg=%b err=%b, required all zero",
                     spi_haddr, spi_hwdata, spi_htrans, spi_hwrite, SPI_change, load_error);
        end
        sclk = 1'b0;
        do_reset();
        tx_q.push_back(32'hFACE_0000);
        tx_q.push_back(32'hFACE_0001);
        spi_frame(32'h0002_2000, 2, 0);
        wait_change(100);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL midreset_reload_count: %0d writes, required 2", obs_q.size());
        end else if (obs_q[0].addr !== 32'h2000 || obs_q[1].addr !== 32'h2004 ||
                     obs_q[0].data !== tx_q[0] || obs_q[1].data !== tx_q[1]) begin
            errors++;
            $display("FAIL midreset_reload: %h/%h %h/%h, required 00002000/%h 00002004/%h",
                     obs_q[0].addr, obs_q[0].data, obs_q[1].addr, obs_q[1].data, tx_q[0], tx_q[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_words();
        test_stall();
        test_abort();
        test_wrap_hresp();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
